mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory answering one core load/store at a time, with WAIT_CYCLES wait states.
// Define MEM_RESP_BYTE_WRITE_EN to honour ByteEn lanes on stores; otherwise every store writes all 32 bits.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  ByteEn,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Fault
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]      offset;
    logic             in_range;
    logic             access_fault;
    logic [IDX_W-1:0] idx;
    logic             mem_we;
    logic [31:0]      wmask;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        unique case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = Addr;
                    wdata_d = WriteData;
                    be_d    = ByteEn;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Range check on the unwrapped offset so a window ending at 2^32 still decodes correctly.
    always_comb begin
        offset       = addr_q - BASE_ADDR;
        in_range     = (addr_q >= BASE_ADDR) && (offset < SPAN);
        access_fault = (rd_q && wr_q) || (addr_q[1:0] != 2'b00) || !in_range;
        idx          = offset[IDX_W+1:2];
        Ready        = (state_q == RESP);
        Fault        = Ready && access_fault;
        ReadData     = (Ready && rd_q && !access_fault) ? mem_q[idx] : '0;
        mem_we       = Ready && wr_q && !access_fault;
`ifdef MEM_RESP_BYTE_WRITE_EN
        wmask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{be_q[i]}};
        end
`else
        wmask = '1;
`endif
    end

    // Storage is intentionally not reset; the write lands on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= (mem_q[idx] & ~wmask) | (wdata_q & wmask);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses, a negedge monitor pops and compares.
// Also runs a WAIT_CYCLES=0 instance to check held-request pacing.
module tb_mem_responder;

    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] Addr = '0, WriteData = '0;
    logic [3:0]  ByteEn = '0;
    logic [31:0] ReadData;
    logic        Ready, Fault;

    logic        rd0 = 1'b0;
    logic        wr0 = 1'b0;
    logic [31:0] addr0 = BASE;
    logic [31:0] wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] rdata0;
    logic        ready0, fault0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr),
        .WriteData(WriteData), .ByteEn(ByteEn), .ReadData(ReadData), .Ready(Ready), .Fault(Fault)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0), .Addr(addr0),
        .WriteData(wdata0), .ByteEn(be0), .ReadData(rdata0), .Ready(ready0), .Fault(fault0)
    );

    typedef struct {
        logic        fault;
        logic [31:0] data;
        logic        chk_data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          resp_cnt = 0;
    logic [31:0] model [DEPTH];
    bit          known [DEPTH];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (Ready) begin
                if (q.size() == 0) begin
                    check("unexpected_ready", {31'b0, Ready}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check({e.name, "_fault"}, {31'b0, Fault}, {31'b0, e.fault});
                    if (e.chk_data) check({e.name, "_rdata"}, ReadData, e.data);
                    check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                end
                resp_cnt++;
            end else begin
                check("idle_fault", {31'b0, Fault}, 32'd0);
                check("idle_rdata", ReadData, 32'd0);
            end
        end
    end

    task automatic issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input string name);
        exp_t        e;
        logic [31:0] off;
        int          idx;
        int          start;
        bit          flt;
        off = a - BASE;
        idx = int'(off >> 2);
        flt = (r && w) || (a[1:0] != 2'b00) || (a < BASE) || ({1'b0, a} >= {1'b0, BASE} + 33'(DEPTH * 4));
        e.name  = name;
        e.fault = flt;
        if (r && !w && !flt) begin
            e.data     = model[idx];
            e.chk_data = known[idx];
        end else begin
            e.data     = '0;
            e.chk_data = 1'b1;
        end
        if (w && !r && !flt) begin
`ifdef MEM_RESP_BYTE_WRITE_EN
            for (int i = 0; i < 4; i++)
                if (b[i]) model[idx][8*i +: 8] = d[8*i +: 8];
            known[idx] = known[idx] || (b == 4'hF);
`else
            model[idx] = d;
            known[idx] = 1'b1;
`endif
        end
        @(negedge clk);
        MemRead = r; MemWrite = w; Addr = a; WriteData = d; ByteEn = b;
        e.cyc = cyc + 1 + int'(W);
        q.push_back(e);
        start = resp_cnt;
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        for (int k = 0; k < 20 && resp_cnt == start; k++) @(negedge clk);
        if (resp_cnt == start) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          pulses, consec;
        bit          prev;
        logic [31:0] a;
        bit          r, w;
        int          kind;

        for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready",  {31'b0, Ready},  32'd0);
        check("rst_fault",  {31'b0, Fault},  32'd0);
        check("rst_rdata",  ReadData,        32'd0);
        check("rst_ready0", {31'b0, ready0}, 32'd0);
        rst = 1'b1;

        // Held read on the zero-wait instance: Ready every second cycle, never back to back.
        pulses = 0; consec = 0; prev = 1'b0;
        @(negedge clk);
        rd0 = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ready0) begin
                pulses++;
                if (prev) consec++;
                check("w0_fault", {31'b0, fault0}, 32'd0);
            end
            prev = ready0;
        end
        rd0 = 1'b0;
        check("w0_pulses", 32'(pulses), 32'd10);
        check("w0_consecutive", 32'(consec), 32'd0);

        issue(0, 1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF, "wr_beef");
        issue(1, 0, 32'h1001_0008, 32'h0, 4'h0, "rd_beef");
        issue(0, 1, 32'h1001_000C, 32'h1122_3344, 4'hF, "wr_base");
        issue(0, 1, 32'h1001_000C, 32'hAABB_CCDD, 4'b0101, "wr_lanes");
        issue(1, 0, 32'h1001_000C, 32'h0, 4'h0, "rd_lanes");
        issue(0, 1, 32'h1001_0010, 32'h5555_AAAA, 4'b0000, "wr_be0");
        issue(1, 0, 32'h1001_0002, 32'h0, 4'h0, "rd_misalign");
        issue(1, 0, 32'h1000_FFFC, 32'h0, 4'h0, "rd_below");
        issue(1, 0, 32'h1001_0100, 32'h0, 4'h0, "rd_above");
        issue(1, 1, 32'h1001_0008, 32'h0, 4'hF, "rd_wr_both");
        issue(0, 1, 32'h1001_000A, 32'h0, 4'hF, "wr_misalign");
        issue(0, 1, 32'h1001_0100, 32'h0, 4'hF, "wr_above");
        issue(1, 0, 32'h1001_0008, 32'h0, 4'h0, "rd_unchanged");
        issue(1, 0, 32'h1001_00FC, 32'h0, 4'h0, "rd_last_word");

        // Abort a write in its wait state; storage must keep the earlier value.
        issue(0, 1, 32'h1001_0000, 32'h1234_5678, 4'hF, "wr_pre");
        @(negedge clk);
        MemWrite = 1'b1; Addr = 32'h1001_0000; WriteData = 32'hCAFE_F00D; ByteEn = 4'hF;
        @(negedge clk);
        MemWrite = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("abort_ready", {31'b0, Ready}, 32'd0);
        check("abort_fault", {31'b0, Fault}, 32'd0);
        check("abort_rdata", ReadData, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        issue(1, 0, 32'h1001_0000, 32'h0, 4'h0, "rd_after_abort");

        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0:       a = BASE + 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                1:       a = BASE - 32'(4 * (1 + $urandom_range(0, 15)));
                2:       a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
                default: a = BASE + 32'(4 * $urandom_range(0, 15));
            endcase
            r = ($urandom_range(0, 1) == 1);
            w = !r;
            if ($urandom_range(0, 11) == 0) begin r = 1'b1; w = 1'b1; end
            issue(r, w, a, $urandom, 4'($urandom_range(0, 15)), "rand");
        end

        repeat (5) @(negedge clk);
        check("pending", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
